// File: rtl/fxu_rs.sv
// fxu_rs: age-ordered reservation station with CDB wakeup that issues the oldest ready op to the FXU.
// Optional synchronous flush input is enabled by defining FXU_RS_FLUSH_EN.
module fxu_rs #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef FXU_RS_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [3:0]                 disp_opcode,
  input  logic [3:0]                 disp_rob,
  input  logic [7:0]                 disp_i,
  input  logic                       disp_a_rdy,
  input  logic [15:0]                disp_a,
  input  logic                       disp_b_rdy,
  input  logic [15:0]                disp_b,
  input  logic                       cdb_valid,
  input  logic [3:0]                 cdb_tag,
  input  logic [15:0]                cdb_value,
  output logic                       issue_valid,
  output logic [3:0]                 issue_opcode,
  output logic [3:0]                 issue_rob,
  output logic [15:0]                issue_va,
  output logic [15:0]                issue_vb,
  output logic [7:0]                 issue_i,
  output logic [$clog2(DEPTH+1)-1:0] rs_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUED = 1'b1} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rob;
    logic [7:0]  imm;
    logic        a_rdy;
    logic [15:0] a_val;
    logic [3:0]  a_tag;
    logic        b_rdy;
    logic [15:0] b_val;
    logic [3:0]  b_tag;
  } entry_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_wr_idx;
  logic          r_disp_ready;
  logic          r_issue_valid;
  logic [3:0]    r_issue_op;
  logic [3:0]    r_issue_rob;
  logic [15:0]   r_issue_va;
  logic [15:0]   r_issue_vb;
  logic [7:0]    r_issue_i;
  entry_t        r_ent [DEPTH];
  entry_t        w_wk  [DEPTH];
  entry_t        w_sh  [DEPTH];
  entry_t        w_nxt [DEPTH];
  entry_t        w_new;
  logic          w_found;
  logic [IW-1:0] w_sel;
  logic          w_issue;
  logic          w_disp;
  logic          w_flush;
  logic          w_movx;

`ifdef FXU_RS_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign disp_ready   = r_disp_ready;
  assign issue_valid  = r_issue_valid;
  assign issue_opcode = r_issue_op;
  assign issue_rob    = r_issue_rob;
  assign issue_va     = r_issue_va;
  assign issue_vb     = r_issue_vb;
  assign issue_i      = r_issue_i;
  assign rs_count     = r_count;

  // Wakeup of buffered operands from the CDB
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_wk[k] = r_ent[k];
      if (cdb_valid && !r_ent[k].a_rdy && (r_ent[k].a_tag == cdb_tag)) begin
        w_wk[k].a_rdy = 1'b1;
        w_wk[k].a_val = cdb_value;
      end else begin
        w_wk[k].a_rdy = r_ent[k].a_rdy;
      end
      if (cdb_valid && !r_ent[k].b_rdy && (r_ent[k].b_tag == cdb_tag)) begin
        w_wk[k].b_rdy = 1'b1;
        w_wk[k].b_val = cdb_value;
      end else begin
        w_wk[k].b_rdy = r_ent[k].b_rdy;
      end
    end
  end

  // Oldest-ready selection on registered state; only the idle state may issue
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_found && (CW'(k) < r_count) && r_ent[k].a_rdy && r_ent[k].b_rdy) begin
        w_found = 1'b1;
        w_sel   = IW'(k);
      end else begin
        w_found = w_found;
      end
    end
    w_issue = (r_state == ST_IDLE) && w_found && !w_flush;
    w_disp  = disp_valid && r_disp_ready && !w_flush;
  end

  // Build the dispatching entry, including same-cycle CDB bypass; MOV-class ops need no B
  always_comb begin
    w_movx      = (disp_opcode == 4'd4) || (disp_opcode == 4'd5) || (disp_opcode == 4'd6);
    w_new       = '0;
    w_new.op    = disp_opcode;
    w_new.rob   = disp_rob;
    w_new.imm   = disp_i;
    w_new.a_tag = disp_a[3:0];
    w_new.b_tag = disp_b[3:0];
    if (disp_a_rdy) begin
      w_new.a_rdy = 1'b1;
      w_new.a_val = disp_a;
    end else if (cdb_valid && (disp_a[3:0] == cdb_tag)) begin
      w_new.a_rdy = 1'b1;
      w_new.a_val = cdb_value;
    end else begin
      w_new.a_rdy = 1'b0;
      w_new.a_val = 16'h0000;
    end
    if (w_movx) begin
      w_new.b_rdy = 1'b1;
      w_new.b_val = 16'h0000;
    end else if (disp_b_rdy) begin
      w_new.b_rdy = 1'b1;
      w_new.b_val = disp_b;
    end else if (cdb_valid && (disp_b[3:0] == cdb_tag)) begin
      w_new.b_rdy = 1'b1;
      w_new.b_val = cdb_value;
    end else begin
      w_new.b_rdy = 1'b0;
      w_new.b_val = 16'h0000;
    end
  end

  // Compaction after issue, then append at the first free slot
  always_comb begin
    w_wr_idx = r_count - CW'(w_issue);
    for (int k = 0; k < DEPTH; k++) begin
      if (w_issue && (IW'(k) >= w_sel) && (k < DEPTH - 1)) begin
        w_sh[k] = w_wk[(k < DEPTH - 1) ? k + 1 : k];
      end else begin
        w_sh[k] = w_wk[k];
      end
      if (w_disp && (CW'(k) == w_wr_idx)) begin
        w_nxt[k] = w_new;
      end else begin
        w_nxt[k] = w_sh[k];
      end
    end
    if (w_flush) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CW'(w_disp) - CW'(w_issue);
    end
  end

  // Issue FSM next state: an issue always costs one hold cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt = ST_ISSUED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUED: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State, buffer and issue payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_disp_ready  <= 1'b1;
      r_issue_valid <= 1'b0;
      r_issue_op    <= 4'h0;
      r_issue_rob   <= 4'h0;
      r_issue_va    <= 16'h0000;
      r_issue_vb    <= 16'h0000;
      r_issue_i     <= 8'h00;
      for (int k = 0; k < DEPTH; k++) begin
        r_ent[k] <= '0;
      end
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_disp_ready  <= (w_count_nxt < CW'(DEPTH));
      r_issue_valid <= w_issue;
      if (w_issue) begin
        r_issue_op  <= r_ent[w_sel].op;
        r_issue_rob <= r_ent[w_sel].rob;
        r_issue_va  <= r_ent[w_sel].a_val;
        r_issue_vb  <= r_ent[w_sel].b_val;
        r_issue_i   <= r_ent[w_sel].imm;
      end
      for (int k = 0; k < DEPTH; k++) begin
        r_ent[k] <= w_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_fxu_rs.sv
// tb_fxu_rs: directed bench for fxu_rs with a queue-based reference model checked every cycle.
module tb_fxu_rs;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [3:0]  disp_opcode = 4'h0;
  logic [3:0]  disp_rob = 4'h0;
  logic [7:0]  disp_i = 8'h00;
  logic        disp_a_rdy = 1'b0;
  logic [15:0] disp_a = 16'h0000;
  logic        disp_b_rdy = 1'b0;
  logic [15:0] disp_b = 16'h0000;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = 4'h0;
  logic [15:0] cdb_value = 16'h0000;
  logic        issue_valid;
  logic [3:0]  issue_opcode;
  logic [3:0]  issue_rob;
  logic [15:0] issue_va;
  logic [15:0] issue_vb;
  logic [7:0]  issue_i;
  logic [2:0]  rs_count;

  fxu_rs #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_rob(disp_rob), .disp_i(disp_i), .disp_a_rdy(disp_a_rdy), .disp_a(disp_a),
    .disp_b_rdy(disp_b_rdy), .disp_b(disp_b), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_rob(issue_rob), .issue_va(issue_va), .issue_vb(issue_vb), .issue_i(issue_i),
    .rs_count(rs_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op, rob;
    logic [7:0]  imm;
    logic        ar, br;
    logic [15:0] av, bv;
    logic [3:0]  at, bt;
  } ent_t;

  ent_t        mq[$];
  logic        m_busy, m_iv;
  logic [3:0]  m_op, m_rob;
  logic [15:0] m_va, m_vb;
  logic [7:0]  m_i;
  logic [3:0]  iss_log[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0; m_iv = 1'b0;
    m_op = 4'h0; m_rob = 4'h0; m_va = 16'h0; m_vb = 16'h0; m_i = 8'h0;
  endtask

  // One clock of the reference behaviour, from the inputs currently applied
  task automatic model_step();
    int   sel;
    bit   acc;
    ent_t n;
    sel = -1;
    acc = disp_valid && (mq.size() < DEPTH);
    if (!m_busy)
      foreach (mq[k]) if (sel < 0 && mq[k].ar && mq[k].br) sel = k;
    m_iv = (sel >= 0);
    if (sel >= 0) begin
      m_op = mq[sel].op; m_rob = mq[sel].rob; m_va = mq[sel].av;
      m_vb = mq[sel].bv; m_i = mq[sel].imm;
      mq.delete(sel);
    end
    m_busy = (sel >= 0);
    foreach (mq[k]) begin
      if (cdb_valid && !mq[k].ar && mq[k].at == cdb_tag) begin mq[k].ar = 1'b1; mq[k].av = cdb_value; end
      if (cdb_valid && !mq[k].br && mq[k].bt == cdb_tag) begin mq[k].br = 1'b1; mq[k].bv = cdb_value; end
    end
    if (acc) begin
      n.op = disp_opcode; n.rob = disp_rob; n.imm = disp_i;
      n.at = disp_a[3:0]; n.bt = disp_b[3:0];
      if (disp_a_rdy) begin n.ar = 1'b1; n.av = disp_a; end
      else if (cdb_valid && disp_a[3:0] == cdb_tag) begin n.ar = 1'b1; n.av = cdb_value; end
      else begin n.ar = 1'b0; n.av = 16'h0; end
      if (disp_opcode inside {4'd4, 4'd5, 4'd6}) begin n.br = 1'b1; n.bv = 16'h0; end
      else if (disp_b_rdy) begin n.br = 1'b1; n.bv = disp_b; end
      else if (cdb_valid && disp_b[3:0] == cdb_tag) begin n.br = 1'b1; n.bv = cdb_value; end
      else begin n.br = 1'b0; n.bv = 16'h0; end
      mq.push_back(n);
    end
  endtask

  // Advance one clock and compare every output against the model
  task automatic step();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
    chk("issue_valid", 32'(issue_valid), 32'(m_iv));
    chk("issue_opcode", 32'(issue_opcode), 32'(m_op));
    chk("issue_rob", 32'(issue_rob), 32'(m_rob));
    chk("issue_va", 32'(issue_va), 32'(m_va));
    chk("issue_vb", 32'(issue_vb), 32'(m_vb));
    chk("issue_i", 32'(issue_i), 32'(m_i));
    chk("rs_count", 32'(rs_count), 32'(mq.size()));
    chk("disp_ready", 32'(disp_ready), 32'(mq.size() < DEPTH));
    if (issue_valid) iss_log.push_back(issue_rob);
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] rob, input logic [7:0] imm,
                      input logic ar, input logic [15:0] a, input logic br, input logic [15:0] b);
    disp_valid = 1'b1; disp_opcode = op; disp_rob = rob; disp_i = imm;
    disp_a_rdy = ar; disp_a = a; disp_b_rdy = br; disp_b = b;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [15:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  initial begin
    model_reset();
    step(); step();
    rst = 1'b0;
    chk("rst_iv", 32'(issue_valid), 32'd0);
    chk("rst_cnt", 32'(rs_count), 32'd0);
    chk("rst_rdy", 32'(disp_ready), 32'd1);

    // ADD with both operands ready
    disp(4'd0, 4'd3, 8'h11, 1'b1, 16'h0005, 1'b1, 16'h0007);
    step(); chk("t1_cnt", 32'(rs_count), 32'd1);
    step(); chk("t1_iv", 32'(issue_valid), 32'd1); chk("t1_rob", 32'(issue_rob), 32'd3);
    chk("t1_va", 32'(issue_va), 32'h5); chk("t1_vb", 32'(issue_vb), 32'h7);
    step(); chk("t1_hold_iv", 32'(issue_valid), 32'd0); chk("t1_hold_va", 32'(issue_va), 32'h5);
    chk("t1_hold_rob", 32'(issue_rob), 32'd3);
    step();

    // SUB waiting on tag 9, woken two cycles later
    disp(4'd1, 4'd2, 8'h22, 1'b0, 16'h0009, 1'b1, 16'h0001);
    step(); step();
    cdb(4'd9, 16'h0010);
    step(); chk("t2_early", 32'(issue_valid), 32'd0);
    step(); chk("t2_iv", 32'(issue_valid), 32'd1); chk("t2_va", 32'(issue_va), 32'h10);
    chk("t2_vb", 32'(issue_vb), 32'h1); chk("t2_rob", 32'(issue_rob), 32'd2);
    step();

    // MOVL with same-cycle bypass on A
    disp(4'd5, 4'd4, 8'h33, 1'b0, 16'h0005, 1'b0, 16'h0003);
    cdb(4'd5, 16'hABCD);
    step(); chk("t3_cnt", 32'(rs_count), 32'd1);
    step(); chk("t3_iv", 32'(issue_valid), 32'd1); chk("t3_va", 32'(issue_va), 32'hABCD);
    chk("t3_vb", 32'(issue_vb), 32'h0); chk("t3_op", 32'(issue_opcode), 32'd5);
    step(); step();

    // Fill, reject a fifth dispatch, then drain in age order
    for (int j = 0; j < 4; j++) begin
      disp(4'd0, 4'(j), 8'(j), 1'b0, 16'h000F, 1'b1, 16'(j));
      step();
    end
    chk("t4_full_rdy", 32'(disp_ready), 32'd0); chk("t4_full_cnt", 32'(rs_count), 32'd4);
    disp(4'd0, 4'd9, 8'h00, 1'b1, 16'h0001, 1'b1, 16'h0001);
    step(); chk("t4_reject", 32'(rs_count), 32'd4);
    cdb(4'd15, 16'h0100);
    step(); chk("t4_wake", 32'(issue_valid), 32'd0);
    for (int j = 0; j < 8; j++) begin
      step();
      if (j % 2 == 0) begin
        chk("t4_iv", 32'(issue_valid), 32'd1);
        chk("t4_rob", 32'(issue_rob), 32'(j / 2));
        chk("t4_cnt", 32'(rs_count), 32'(3 - j / 2));
      end
    end
    step();

    // Younger ready op overtakes older waiting ones; the older pair keeps its order
    iss_log.delete();
    disp(4'd0, 4'd6, 8'h00, 1'b0, 16'h0007, 1'b1, 16'h0001); step();
    disp(4'd1, 4'd7, 8'h00, 1'b0, 16'h0007, 1'b1, 16'h0002); step();
    disp(4'd0, 4'd8, 8'h00, 1'b1, 16'h0003, 1'b1, 16'h0004); step();
    step(); step();
    cdb(4'd7, 16'h0042);
    for (int j = 0; j < 6; j++) step();
    chk("t5_n", 32'(iss_log.size()), 32'd3);
    if (iss_log.size() == 3) begin
      chk("t5_first", 32'(iss_log[0]), 32'd8);
      chk("t5_second", 32'(iss_log[1]), 32'd6);
      chk("t5_third", 32'(iss_log[2]), 32'd7);
    end

    // Asynchronous reset while an issue is presented and three entries are held
    for (int j = 1; j < 4; j++) begin
      disp(4'd0, 4'(j), 8'h00, 1'b0, 16'h000B, 1'b1, 16'h0000);
      step();
    end
    disp(4'd1, 4'd5, 8'h5A, 1'b1, 16'h0077, 1'b1, 16'h0066); step();
    step(); chk("t6_iv", 32'(issue_valid), 32'd1); chk("t6_cnt", 32'(rs_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_iv", 32'(issue_valid), 32'd0); chk("t6_rst_cnt", 32'(rs_count), 32'd0);
    chk("t6_rst_va", 32'(issue_va), 32'd0); chk("t6_rst_rob", 32'(issue_rob), 32'd0);
    chk("t6_rst_rdy", 32'(disp_ready), 32'd1);
    step();
    rst = 1'b0;
    step();

    // Mixed traffic: concurrent dispatch, issue and wakeup, unknown opcodes included
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 1) == 0) begin
        disp(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'($urandom),
             1'($urandom_range(0, 1)), 16'($urandom) & 16'hFFF3,
             1'($urandom_range(0, 1)), 16'($urandom) & 16'hFFF3);
      end
      if ($urandom_range(0, 2) == 0) cdb(4'($urandom_range(0, 3)), 16'($urandom));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
